// File: rtl/lstm_fixed_pkg.sv
// Shared Q2.14 fixed-point definitions for the LSTM datapath stages.
// Used by the row accumulator and later by the activation and cell-update stages.
package lstm_fixed_pkg;

    localparam int Q_FRAC       = 14;
    localparam int Q_DATA_WIDTH = 16;

    localparam logic signed [Q_DATA_WIDTH-1:0] Q_MAX = 16'sd32767;
    localparam logic signed [Q_DATA_WIDTH-1:0] Q_MIN = -16'sd32768;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/mac_row_accumulator_if.sv
// Partial-sum input stream, row configuration and result output of the row accumulator.
interface mac_row_accumulator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
);

    // Handshake: a transfer happens on a rising clock edge where valid and ready are
    // both high; the sender holds data stable while valid is high and ready is low.
    logic                           in_valid;
    logic                           in_ready;
    logic signed [2*DATA_WIDTH-1:0] in_psum;
    logic        [CNT_WIDTH-1:0]    cfg_chunks;
    logic signed [DATA_WIDTH-1:0]   bias;
    logic                           out_valid;
    logic                           out_ready;
    logic signed [DATA_WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_psum, cfg_chunks, bias, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_psum, cfg_chunks, bias, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/q_saturate.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits with a clamped flag.
module q_saturate #(
    parameter int IN_W  = 40,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_clamped
);

    localparam logic signed [IN_W-1:0] MAX_IN = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_IN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        o_val     = i_val[OUT_W-1:0];
        o_clamped = 1'b0;
        if (i_val > MAX_IN) begin
            o_val     = {1'b0, {(OUT_W-1){1'b1}}};
            o_clamped = 1'b1;
        end else if (i_val < MIN_IN) begin
            o_val     = {1'b1, {(OUT_W-1){1'b0}}};
            o_clamped = 1'b1;
        end
    end

endmodule

// File: rtl/mac_row_accumulator.sv
// Accumulates per-chunk MAC partial sums plus bias for one row, then emits a saturated Q2.14 result.
// Optional MAC_ROW_ACC_SAT_FLAG_EN adds the out_sat flag and the sat_count debug counter.
module mac_row_accumulator
    import lstm_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mac_row_accumulator_if.slave   bus,
    output logic                   busy,
    output acc_state_t             dbg_state
`ifdef MAC_ROW_ACC_SAT_FLAG_EN
    ,
    output logic                   out_sat,
    output logic [15:0]            sat_count
`endif
);

    acc_state_t                   r_state;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic        [CNT_WIDTH-1:0]  r_cnt;
    logic        [CNT_WIDTH-1:0]  r_tgt;
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_out_data;

    logic                         w_beat;
    logic                         w_take;
    logic                         w_last;
    logic        [CNT_WIDTH-1:0]  w_tgt_first;
    logic signed [ACC_WIDTH-1:0]  w_bias_ext;
    logic signed [ACC_WIDTH-1:0]  w_psum_ext;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic signed [DATA_WIDTH-1:0] w_sat_data;
    logic                         w_clamped;

    assign bus.in_ready  = (r_state != DONE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign busy          = (r_state != IDLE);
    assign dbg_state     = r_state;

    assign w_beat = bus.in_valid && bus.in_ready;
    assign w_take = r_out_valid && bus.out_ready;

    // A zero chunk count still consumes the one beat that opens the row.
    assign w_tgt_first = (bus.cfg_chunks == '0) ? CNT_WIDTH'(1) : bus.cfg_chunks;

    assign w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bus.bias[DATA_WIDTH-1]}}, bus.bias};
    assign w_psum_ext = {{(ACC_WIDTH-2*DATA_WIDTH){bus.in_psum[2*DATA_WIDTH-1]}}, bus.in_psum};
    assign w_acc_next = (r_state == IDLE) ? (w_bias_ext + w_psum_ext) : (r_acc + w_psum_ext);

    always_comb begin
        w_last = 1'b0;
        if (w_beat) begin
            if (r_state == IDLE) begin
                w_last = (w_tgt_first == CNT_WIDTH'(1));
            end else begin
                w_last = ((r_cnt + CNT_WIDTH'(1)) == r_tgt);
            end
        end
    end

    // Saturate the value being written on the final beat so out_data is registered on DONE entry.
    q_saturate #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (DATA_WIDTH)
    ) u_sat (
        .i_val     (w_acc_next),
        .o_val     (w_sat_data),
        .o_clamped (w_clamped)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_tgt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        r_tgt <= w_tgt_first;
                        r_acc <= w_acc_next;
                        r_cnt <= CNT_WIDTH'(1);
                        if (w_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_sat_data;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                        if (w_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_sat_data;
                        end
                    end
                end
                DONE: begin
                    if (w_take) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAC_ROW_ACC_SAT_FLAG_EN
    logic        r_out_sat;
    logic [15:0] r_sat_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_sat   <= 1'b0;
            r_sat_count <= '0;
        end else if (w_last) begin
            r_out_sat <= w_clamped;
            if (w_clamped && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
        end
    end

    assign out_sat   = r_out_sat;
    assign sat_count = r_sat_count;
`else
    logic w_unused_clamped;
    assign w_unused_clamped = w_clamped;
`endif

endmodule
